prog_loader: RTL
================

Name: prog_loader

Overview:
- UART program loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Receives a framed program image over a serial line, assembles 32-bit words and writes them into instruction memory.
- Holds the CPU in reset while loading and releases it once the checksum matches.
- Exposes a loaded-word count for the HEX debug displays.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated.
- ADDR_W, 8, log2 of instruction memory depth in words; maximum image = 2**ADDR_W words.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- rxd  in  1  serial input, idle high, 8N1, LSB first, asynchronous to CLK.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  32  byte address of write (word_index*4, bits [1:0]=0).
- imem_wd  out  32  write data word.
- cpu_rst_n  out  1  active-low CPU reset; low while not in RUN.
- busy  out  1  high in LEN_HI, LEN_LO, DATA, CSUM.
- err  out  1  high in ERR.
- word_cnt  out  16  words written in current/last load.

Behaviour:
- Reset (RST low, async): state=SYNC, imem_we=0, imem_addr=0, imem_wd=0, cpu_rst_n=0, busy=0, err=0, word_cnt=0, receiver idle.
- rxd passes through a 2-flop synchroniser before any use.
- Receiver:
  - Synchronised falling edge in idle starts a byte; wait CLKS_PER_BIT/2 and re-sample; if high, treat as a glitch and return to idle.
  - Sample 8 data bits at successive bit centres (every CLKS_PER_BIT clocks), LSB first.
  - Sample stop bit; 1 -> byte_valid pulses for one cycle with the byte; 0 -> framing error pulse, no byte_valid.
  - A new start edge is accepted only after the stop-bit sample.
- Frame format: 0x55 sync, LEN_HI, LEN_LO (word count N, big-endian), N*4 data bytes (each word little-endian, first byte -> bits[7:0]), CSUM = 8-bit sum mod 256 of all data bytes.
- State machine (advances only on byte_valid or framing error):
  - SYNC: byte 0x55 -> LEN_HI; other bytes are ignored.
  - LEN_HI: latch high byte -> LEN_LO.
  - LEN_LO:
    - N > 2**ADDR_W -> ERR.
    - N = 0 -> CSUM, expected sum 0.
    - Otherwise -> DATA, with word_index=0, byte_lane=0, sum=0 and word_cnt=0.
  - DATA:
    - Shift the byte into its lane and add it to sum.
    - On lane 3: the next cycle drives imem_we=1 for exactly one cycle, with imem_addr=word_index*4 and imem_wd=the assembled word; word_index and word_cnt increment in that same cycle.
    - After word N is written -> CSUM.
  - CSUM: byte == sum -> RUN; mismatch -> ERR.
  - RUN: cpu_rst_n=1, registered, rising the cycle after the CSUM byte_valid. A byte 0x55 -> LEN_HI with cpu_rst_n=0 the next cycle (reload). Other bytes are ignored.
  - ERR: err=1, cpu_rst_n=0. Byte 0x55 -> LEN_HI and clears err.
  - Framing error in LEN_HI, LEN_LO, DATA or CSUM -> ERR. Framing error in SYNC, RUN or ERR is ignored.
- Entering LEN_HI from any state clears word_cnt.
- imem_addr and imem_wd hold their last values when imem_we=0.
- Memory writes already issued before an error are not undone; the CPU stays in reset until a good frame completes.
- Reset asserted mid-frame aborts immediately; the partial frame is discarded and the next frame must start with sync.
- Checksum and address arithmetic wrap naturally: 8-bit for sum, ADDR_W bits for word_index.

Test Plan:
- Bench uses CLK_HZ=1600000, BAUD=100000, so 16 clocks/bit.
- Basic load: frame 55 00 02 | 13 00 00 20 | 2A 00 01 AC | checksum 0x0A -> two imem_we pulses: addr 0x0 with 0x20000013, then addr 0x4 with 0xAC01002A; word_cnt=2; cpu_rst_n rises one cycle after the checksum byte; err=0.
- Bad checksum: same frame with checksum 0x0B -> both writes occur; state ERR, err=1, cpu_rst_n stays 0; a following good frame clears err and releases the CPU.
- Oversize/empty: LEN=0x0101 with ADDR_W=8 -> ERR with no writes. LEN=0x0000 with checksum 0x00 -> RUN, word_cnt=0.
- Line errors:
  - Stop bit forced 0 on the 3rd data byte -> ERR, no imem_we for that word.
  - A 4-clock low glitch on idle rxd -> no byte received, state unchanged.
- Reload and reset: in RUN send 0x55 -> cpu_rst_n falls next cycle and busy=1. Separately, assert RST mid-DATA -> all outputs return to reset values and the next bytes without 0x55 are ignored.

Source files
------------

// File: rtl/prog_loader.sv
// UART program loader: receives a framed program image (8N1), writes 32-bit words into
// instruction memory and holds the CPU in reset until the image checksum matches.
module prog_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rxd,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        err,
  output logic [15:0] word_cnt
);

  localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS    = 17'(2 ** ADDR_W);
  localparam logic [7:0]  SYNC_BYTE    = 8'h55;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

  rx_state_t         rx_state_r;
  logic              rxd_meta_r, rxd_sync_r, rxd_prev_r;
  logic [15:0]       rx_cnt_r;
  logic [2:0]        rx_bit_r;
  logic [7:0]        rx_shift_r, rx_byte_r;
  logic              byte_valid_r, frame_err_r;

  state_t            state_r;
  logic [7:0]        len_hi_r, sum_r;
  logic [15:0]       len_r;
  logic [1:0]        lane_r;
  logic [31:0]       word_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic              wr_pend_r;

  // Serial receiver: synchroniser, start-bit validation at half bit, centre sampling.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rxd_meta_r   <= 1'b1;
      rxd_sync_r   <= 1'b1;
      rxd_prev_r   <= 1'b1;
      rx_state_r   <= RX_IDLE;
      rx_cnt_r     <= 16'd0;
      rx_bit_r     <= 3'd0;
      rx_shift_r   <= 8'd0;
      rx_byte_r    <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      rxd_meta_r   <= rxd;
      rxd_sync_r   <= rxd_meta_r;
      rxd_prev_r   <= rxd_sync_r;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= 16'd0;
          if (rxd_prev_r && !rxd_sync_r) begin
            rx_state_r <= RX_START;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_state_r <= rxd_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
            rx_bit_r   <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= RX_IDLE;
            if (rxd_sync_r) begin
              byte_valid_r <= 1'b1;
              rx_byte_r    <= rx_shift_r;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Frame parser, word assembly and memory write; busy/err/cpu_rst_n change with state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= S_SYNC;
      len_hi_r   <= 8'd0;
      len_r      <= 16'd0;
      sum_r      <= 8'd0;
      lane_r     <= 2'd0;
      word_r     <= 32'd0;
      word_idx_r <= '0;
      wr_pend_r  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wd    <= 32'd0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= 16'd0;
    end else begin
      imem_we <= 1'b0;
      if (wr_pend_r) begin
        imem_we    <= 1'b1;
        imem_addr  <= {{(30 - ADDR_W){1'b0}}, word_idx_r, 2'b00};
        imem_wd    <= word_r;
        word_idx_r <= word_idx_r + ADDR_W'(1);
        word_cnt   <= word_cnt + 16'd1;
        wr_pend_r  <= 1'b0;
      end
      if (frame_err_r) begin
        if (busy) begin
          state_r   <= S_ERR;
          busy      <= 1'b0;
          err       <= 1'b1;
          cpu_rst_n <= 1'b0;
        end
      end else if (byte_valid_r) begin
        case (state_r)
          S_SYNC, S_RUN, S_ERR: begin
            if (rx_byte_r == SYNC_BYTE) begin
              state_r   <= S_LEN_HI;
              busy      <= 1'b1;
              err       <= 1'b0;
              cpu_rst_n <= 1'b0;
              word_cnt  <= 16'd0;
            end
          end
          S_LEN_HI: begin
            len_hi_r <= rx_byte_r;
            state_r  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_r      <= {len_hi_r, rx_byte_r};
            sum_r      <= 8'd0;
            lane_r     <= 2'd0;
            word_idx_r <= '0;
            word_cnt   <= 16'd0;
            if ({1'b0, len_hi_r, rx_byte_r} > MAX_WORDS) begin
              state_r <= S_ERR;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else if ({len_hi_r, rx_byte_r} == 16'd0) begin
              state_r <= S_CSUM;
            end else begin
              state_r <= S_DATA;
            end
          end
          S_DATA: begin
            word_r[{lane_r, 3'b000} +: 8] <= rx_byte_r;
            sum_r  <= sum_r + rx_byte_r;
            lane_r <= lane_r + 2'd1;
            if (lane_r == 2'd3) begin
              wr_pend_r <= 1'b1;
              if (word_cnt + 16'd1 == len_r) begin
                state_r <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            busy <= 1'b0;
            if (rx_byte_r == sum_r) begin
              state_r   <= S_RUN;
              cpu_rst_n <= 1'b1;
            end else begin
              state_r <= S_ERR;
              err     <= 1'b1;
            end
          end
          default: state_r <= S_SYNC;
        endcase
      end
    end
  end

endmodule
